universal_shift_reg: RTL and testbench

- Parametrised successor to the team's 4-bit bidirectional serial shift register.
- Generalised to WIDTH bits, with these operations: hold, shift left/right, rotate left/right, arithmetic shift right, parallel load and clear.
- Adds a multi-step burst engine: one start pulse runs N consecutive shifts/rotates under a busy/done handshake.
- Used as a serialiser/deserialiser and barrel-shift substitute in datapath blocks.

---
 rtl/universal_shift_reg.sv | 143 ++++++++++++++
 tb/tb_universal_shift_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : universal_shift_reg
// Purpose  : WIDTH-bit universal shift register. Supports hold, shift and
//            rotate in both directions, arithmetic shift right, parallel load
//            and clear, plus a burst engine that runs N shifts or rotates from
//            one start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdata_in,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] C_HOLD = 3'b000;
  localparam logic [2:0] C_SHL  = 3'b001;
  localparam logic [2:0] C_SHR  = 3'b010;
  localparam logic [2:0] C_ROL  = 3'b011;
  localparam logic [2:0] C_ROR  = 3'b100;
  localparam logic [2:0] C_ASR  = 3'b101;
  localparam logic [2:0] C_LOAD = 3'b110;
  localparam logic [2:0] C_CLR  = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_q, w_q_n;
  logic [CNT_W-1:0] r_rem, w_rem_n;
  logic [2:0]       r_lmode, w_lmode_n;
  logic             r_done, w_done_n;

  // Next value of the register for one edge of the selected operation.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             s_r,
    input logic             s_l,
    input logic [WIDTH-1:0] pd
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      C_SHL:   res = {cur[WIDTH-2:0], s_l};
      C_SHR:   res = {s_r, cur[WIDTH-1:1]};
      C_ROL:   res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      C_ROR:   res = {cur[0], cur[WIDTH-1:1]};
      C_ASR:   res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      C_LOAD:  res = pd;
      C_CLR:   res = '0;
      default: res = cur;  // hold
    endcase
    return res;
  endfunction

  // Only the five shift/rotate operations are worth repeating in a burst.
  function automatic logic is_burst_op(input logic [2:0] op);
    return (op != C_HOLD) && (op != C_LOAD) && (op != C_CLR);
  endfunction

  // State, data and burst bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_lmode <= C_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_q     <= w_q_n;
      r_rem   <= w_rem_n;
      r_lmode <= w_lmode_n;
      r_done  <= w_done_n;
    end
  end

  // Next-state and datapath selection; start has priority over en in IDLE.
  always_comb begin
    w_state_n = r_state;
    w_q_n     = r_q;
    w_rem_n   = r_rem;
    w_lmode_n = r_lmode;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            // Zero-length request: acknowledge without touching q.
            w_done_n = 1'b1;
          end else if (is_burst_op(mode)) begin
            w_lmode_n = mode;
            w_rem_n   = count;
            w_state_n = RUN;
          end else begin
            // Hold/load/clear are idempotent, so run them once and finish.
            w_q_n    = apply_op(mode, r_q, sin_r, sin_l, pdata_in);
            w_done_n = 1'b1;
          end
        end else if (en) begin
          w_q_n = apply_op(mode, r_q, sin_r, sin_l, pdata_in);
        end
      end
      RUN: begin
        // Serial inputs stay live so a burst can stream data in.
        w_q_n = apply_op(r_lmode, r_q, sin_r, sin_l, pdata_in);
        if (r_rem == CNT_W'(1)) begin
          w_rem_n   = '0;
          w_state_n = IDLE;
          w_done_n  = 1'b1;
        end else begin
          w_rem_n = r_rem - CNT_W'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign q      = r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];
  assign busy   = (r_state == RUN);
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_universal_shift_reg
// Purpose  : Directed self-checking bench for universal_shift_reg (8-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] count;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pdata_in;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  int tests_run;
  int tests_failed;
  int nb;

  universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .mode     (mode),
    .count    (count),
    .sin_r    (sin_r),
    .sin_l    (sin_l),
    .pdata_in (pdata_in),
    .q        (q),
    .sout_r   (sout_r),
    .sout_l   (sout_l),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    en = 1'b1; mode = 3'b110; pdata_in = v;
    step();
    en = 1'b0; mode = 3'b000;
  endtask

  // Pulse start for one edge, then count cycles while busy (bounded).
  task automatic burst(input logic [2:0] m, input logic [CNT_W-1:0] n);
    mode = m; count = n; start = 1'b1;
    step();
    start = 1'b0; mode = 3'b000; count = '0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      step();
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b0; en = 1'b0; start = 1'b0; mode = 3'b000; count = '0;
    sin_r = 1'b0; sin_l = 1'b0; pdata_in = '0;

    // 1. Reset state and parallel load
    #3;
    check("rst_q", q, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    #10 rst = 1'b1;
    step();
    load(8'hA5);
    check("load_A5", q, 8'hA5);

    // 2. Single steps and hold
    en = 1'b1; mode = 3'b010; sin_r = 1'b1;
    step();
    check("shr_q", q, 8'hD2);
    check("shr_sout_r", sout_r, 1'b0);
    mode = 3'b001; sin_l = 1'b0; sin_r = 1'b0;
    step();
    check("shl_q", q, 8'hA4);
    check("shl_sout_l", sout_l, 1'b1);
    en = 1'b0; mode = 3'b111;
    step(); step();
    check("hold_q", q, 8'hA4);
    check("step_done", done, 1'b0);

    // 3. Rotate-left burst, start mid-burst ignored
    load(8'h81);
    mode = 3'b011; count = 4'd3; start = 1'b1;
    step();
    start = 1'b0; count = '0;
    check("rol_busy0", busy, 1'b1);
    check("rol_q0", q, 8'h81);
    step();
    check("rol_q1", q, 8'h03);
    mode = 3'b111; count = 4'd5; start = 1'b1; en = 1'b1;
    step();
    start = 1'b0; en = 1'b0; mode = 3'b000; count = '0;
    check("rol_q2", q, 8'h06);
    check("rol_busy2", busy, 1'b1);
    check("rol_done2", done, 1'b0);
    step();
    check("rol_q3", q, 8'h0C);
    check("rol_busy3", busy, 1'b0);
    check("rol_done3", done, 1'b1);
    step();
    check("rol_done_pulse", done, 1'b0);
    check("rol_q_after", q, 8'h0C);

    // 4. Arithmetic shift burst and full rotate-right
    load(8'h90);
    burst(3'b101, 4'd4);
    check("asr_cycles", nb, 4);
    check("asr_q", q, 8'hF9);
    check("asr_done", done, 1'b1);
    load(8'h3C);
    burst(3'b100, 4'd8);
    check("ror8_cycles", nb, 8);
    check("ror8_q", q, 8'h3C);
    check("ror8_done", done, 1'b1);

    // 5. Zero count, then a start while done is high (clear)
    step();
    mode = 3'b001; count = 4'd0; start = 1'b1;
    step();
    check("cnt0_done", done, 1'b1);
    check("cnt0_busy", busy, 1'b0);
    check("cnt0_q", q, 8'h3C);
    mode = 3'b111; count = 4'd1;
    step();
    start = 1'b0; mode = 3'b000; count = '0;
    check("clr_q", q, 8'h00);
    check("clr_done", done, 1'b1);
    check("clr_busy", busy, 1'b0);
    step();
    check("clr_done_pulse", done, 1'b0);

    // 6. Reset during a burst, live serial input
    load(8'h0F);
    sin_r = 1'b1;
    mode = 3'b010; count = 4'd10; start = 1'b1;
    step();
    start = 1'b0; mode = 3'b000; count = '0;
    step(); step();
    check("abort_q_before", q, 8'hC3);
    check("abort_busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("abort_q", q, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    step();
    #4 rst = 1'b1;
    sin_r = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) check("post_rst_idle", {busy, done}, 2'b00);
    end
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_q", q, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
